ro_freq_counter: RTL and testbench

// - Downstream measurement stage for a ring oscillator. Drives the ring's enable and

---
 rtl/ro_freq_counter.sv | 127 ++++++++++++
 tb/tb_ro_freq_counter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: enables the ring, waits a warm-up period, then counts
// synchronised rising edges over a programmable clk window. Define RO_CNT_SAT_EN to saturate.
module ro_freq_counter #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned WIN_W         = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned WARMUP_CYCLES = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIN_W-1:0] i_window_len,
    input  logic             i_osc_in,
    output logic             o_osc_enable,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    localparam int unsigned WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {StIdle, StWarmup, StCount, StDone} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic [WIN_W-1:0]       r_win;
    logic [WARM_W-1:0]      r_warm;
    logic [CNT_W-1:0]       r_acc;
    logic                   r_ovf;
    logic                   r_osc_en;
    logic                   r_busy;
    logic                   r_done;
    logic [CNT_W-1:0]       r_count;
    logic                   r_overflow;

    logic                   w_sync_out;
    logic                   w_rise;
    logic                   w_acc_at_max;
    logic [CNT_W-1:0]       w_acc_inc;
    logic [CNT_W-1:0]       w_acc_next;
    logic                   w_ovf_next;
    logic [WIN_W-1:0]       w_win_load;

    assign w_sync_out   = r_sync[SYNC_STAGES-1];
    assign w_rise       = w_sync_out & ~r_sync_prev;
    assign w_acc_at_max = (r_acc == CNT_MAX);
`ifdef RO_CNT_SAT_EN
    assign w_acc_inc    = w_acc_at_max ? r_acc : r_acc + CNT_W'(1);
`else
    assign w_acc_inc    = r_acc + CNT_W'(1);
`endif
    assign w_acc_next   = w_rise ? w_acc_inc : r_acc;
    // Flag is sticky for the whole measurement once an increment hits the max value.
    assign w_ovf_next   = r_ovf | (w_rise & w_acc_at_max);
    assign w_win_load   = (i_window_len == '0) ? WIN_W'(1) : i_window_len;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_win       <= '0;
            r_warm      <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_osc_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], i_osc_in};
            r_sync_prev <= w_sync_out;
            r_done      <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state  <= StWarmup;
                        r_win    <= w_win_load;
                        r_warm   <= WARM_LOAD;
                        r_acc    <= '0;
                        r_ovf    <= 1'b0;
                        r_osc_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                StWarmup: begin
                    if (r_warm == '0) begin
                        r_state <= StCount;
                    end else begin
                        r_warm <= r_warm - WARM_W'(1);
                    end
                end
                StCount: begin
                    r_acc <= w_acc_next;
                    r_ovf <= w_ovf_next;
                    // Publish the result together with the move to DONE so it is valid with done.
                    if (r_win == WIN_W'(1)) begin
                        r_state    <= StDone;
                        r_osc_en   <= 1'b0;
                        r_done     <= 1'b1;
                        r_count    <= w_acc_next;
                        r_overflow <= w_ovf_next;
                    end else begin
                        r_win <= r_win - WIN_W'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_osc_enable = r_osc_en;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_count      = r_count;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: a default instance plus a CNT_W=4 instance sharing stimulus.
module tb_ro_freq_counter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] window_len;
    logic        osc;
    int          osc_mode;

    logic        en, busy, done, ovf;
    logic [15:0] count;
    logic        en4, busy4, done4, ovf4;
    logic [3:0]  count4;

    int n_tests;
    int n_fail;

    ro_freq_counter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_window_len(window_len),
        .i_osc_in    (osc),
        .o_osc_enable(en),
        .o_busy      (busy),
        .o_done      (done),
        .o_count     (count),
        .o_overflow  (ovf)
    );

    ro_freq_counter #(.CNT_W(4)) dut4 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_window_len(window_len),
        .i_osc_in    (osc),
        .o_osc_enable(en4),
        .o_busy      (busy4),
        .o_done      (done4),
        .o_count     (count4),
        .o_overflow  (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: held low; mode 1: toggle every 5 clk; mode 2: toggle every clk
    initial begin
        int ph;
        osc = 1'b0;
        ph  = 0;
        forever begin
            @(negedge clk);
            if (osc_mode == 0) begin
                osc = 1'b0;
            end else if (osc_mode == 2) begin
                osc = ~osc;
            end else begin
                ph = ph + 1;
                if (ph >= 5) begin
                    ph  = 0;
                    osc = ~osc;
                end
            end
        end
    end

    // Caller is at a negedge. Index j = values seen just before clk edge T+j.
    task automatic run(input int win, input bit ign, output int done_cnt, output int done_at,
                       output int busy_err, output int en_err, output int hold_err);
        int          eff;
        int          last;
        logic [15:0] old_count;
        eff       = (win == 0) ? 1 : win;
        last      = 9 + eff;
        old_count = count;
        done_cnt  = 0;
        done_at   = -1;
        busy_err  = 0;
        en_err    = 0;
        hold_err  = 0;
        start      = 1'b1;
        window_len = 16'(win);
        for (int j = 1; j <= last + 1; j++) begin
            @(negedge clk);
            start = ign && (j == 3 || j == 20 || j == last);
            if (ign && j == 2) window_len = 16'd7;
            if (ign && j == 40) window_len = 16'd0;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (busy !== (j <= last)) busy_err++;
            if (en !== (j < last)) en_err++;
            if (j < last && count !== old_count) hold_err++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        window_len = 16'd0;
        osc_mode = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({en, busy, done, ovf, count} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b busy=%b done=%b ovf=%b count=%0d want all 0",
                     en, busy, done, ovf, count);
        end
        n_tests++;
        if ({en4, busy4, done4, ovf4, count4} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs4: got en=%b busy=%b done=%b ovf=%b count=%0d want 0",
                     en4, busy4, done4, ovf4, count4);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal;
        int dc, da, be, ee, he;
        osc_mode = 1;
        repeat (3) @(negedge clk);
        run(100, 1'b0, dc, da, be, ee, he);
        n_tests++;
        if (dc !== 1 || da !== 109) begin
            n_fail++;
            $display("FAIL nominal_done: got %0d pulses first at %0d want 1 at 109", dc, da);
        end
        n_tests++;
        if (count !== 16'd10 && count !== 16'd11) begin
            n_fail++;
            $display("FAIL nominal_count: got %0d want 10 or 11", count);
        end
        n_tests++;
        if (ovf !== 1'b0 || ovf4 !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_ovf: got %b/%b want 0/0", ovf, ovf4);
        end
        n_tests++;
        if (be !== 0 || ee !== 0) begin
            n_fail++;
            $display("FAIL nominal_busy_en: got %0d busy, %0d enable errors want 0", be, ee);
        end
    endtask

    task automatic test_reset_in_count;
        int bad;
        bad = 0;
        osc_mode = 1;
        start = 1'b1;
        window_len = 16'd100;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (j == 29) begin
                n_tests++;
                if (busy !== 1'b1 || en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rst_pre_busy: got busy=%b en=%b want 1/1", busy, en);
                end
            end
            if (j == 30) rst_n = 1'b0;
            if (j == 31) begin
                n_tests++;
                if ({en, busy, done, ovf, count} !== 20'd0) begin
                    n_fail++;
                    $display("FAIL rst_in_count: got en=%b busy=%b done=%b ovf=%b count=%0d want 0",
                             en, busy, done, ovf, count);
                end
            end
            if (j == 32) rst_n = 1'b1;
        end
        for (int j = 0; j < 150; j++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || en !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rst_no_done: got %0d cycles with done/busy/en high want 0", bad);
        end
    endtask

    task automatic test_quiet;
        int dc, da, be, ee, he;
        osc_mode = 0;
        repeat (4) @(negedge clk);
        run(0, 1'b0, dc, da, be, ee, he);
        n_tests++;
        if (dc !== 1 || da !== 10) begin
            n_fail++;
            $display("FAIL quiet_done: got %0d pulses first at %0d want 1 at 10", dc, da);
        end
        n_tests++;
        if (count !== 16'd0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL quiet_result: got count=%0d ovf=%b want 0/0", count, ovf);
        end
        n_tests++;
        if (be !== 0 || ee !== 0) begin
            n_fail++;
            $display("FAIL quiet_busy_en: got %0d busy, %0d enable errors want 0", be, ee);
        end
    endtask

    task automatic test_ignore;
        int dc, da, be, ee, he;
        osc_mode = 2;
        repeat (2) @(negedge clk);
        run(40, 1'b1, dc, da, be, ee, he);
        n_tests++;
        if (dc !== 1 || da !== 49) begin
            n_fail++;
            $display("FAIL ignore_done: got %0d pulses first at %0d want 1 at 49", dc, da);
        end
        n_tests++;
        if (count !== 16'd20 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: got count=%0d ovf=%b want 20/0", count, ovf);
        end
        n_tests++;
        if (be !== 0 || ee !== 0) begin
            n_fail++;
            $display("FAIL ignore_busy_en: got %0d busy, %0d enable errors want 0", be, ee);
        end
    endtask

    task automatic test_overflow;
        int dc, da, be, ee, he;
        osc_mode = 2;
        repeat (2) @(negedge clk);
        run(64, 1'b0, dc, da, be, ee, he);
        n_tests++;
        if (dc !== 1 || da !== 73) begin
            n_fail++;
            $display("FAIL ovf_done: got %0d pulses first at %0d want 1 at 73", dc, da);
        end
        n_tests++;
        if (count !== 16'd32 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_wide: got count=%0d ovf=%b want 32/0", count, ovf);
        end
`ifdef RO_CNT_SAT_EN
        n_tests++;
        if (count4 !== 4'd15 || ovf4 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_narrow_sat: got count=%0d ovf=%b want 15/1", count4, ovf4);
        end
`else
        n_tests++;
        if (count4 !== 4'd0 || ovf4 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_narrow_wrap: got count=%0d ovf=%b want 0/1", count4, ovf4);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int dc, da, be, ee, he;
        osc_mode = 2;
        repeat (2) @(negedge clk);
        run(100, 1'b0, dc, da, be, ee, he);
        n_tests++;
        if (dc !== 1 || da !== 109 || count !== 16'd50 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_run1: got %0d pulses at %0d count=%0d ovf=%b want 1 at 109 50/0",
                     dc, da, count, ovf);
        end
        n_tests++;
        if (en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got en=%b busy=%b in idle gap want 0/0", en, busy);
        end
        // Called at index 110 of run 1, so the new start lands on edge T+110.
        run(60, 1'b0, dc, da, be, ee, he);
        n_tests++;
        if (he !== 0) begin
            n_fail++;
            $display("FAIL b2b_hold: got %0d cycles with run1 result disturbed want 0", he);
        end
        n_tests++;
        if (dc !== 1 || da !== 69 || count !== 16'd30 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_run2: got %0d pulses at %0d count=%0d ovf=%b want 1 at 69 30/0",
                     dc, da, count, ovf);
        end
        n_tests++;
        if (be !== 0 || ee !== 0) begin
            n_fail++;
            $display("FAIL b2b_busy_en: got %0d busy, %0d enable errors want 0", be, ee);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        osc_mode = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        window_len = 16'd0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_reset_in_count();
        test_quiet();
        test_ignore();
        test_overflow();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
